// File: rtl/regular_pulse_gen.sv
// -----------------------------------------------------------------------------
// regular_pulse_gen
//
// Purpose:
//   Sits behind an upward counter and consumes its wrap strobe (tick). Each
//   tick advances an internal phase counter; the block turns that phase into a
//   regular pulse train on pulse_out. Period, high width and number of periods
//   are programmable. A pulse count of zero selects free-running mode.
//   A start/stop handshake and a one-cycle done strobe let the surrounding
//   control logic sequence trains.
//
// Optional feature (macro REGULAR_PULSE_POLARITY_EN):
//   Adds a polarity input that is latched on an accepted start. With polarity
//   latched as 1 the pulse train is inverted while running, and pulse_out
//   rests at the latched polarity in IDLE and DONE. Reset still clears
//   pulse_out and the latched polarity to 0. With the macro undefined the
//   port does not exist and pulse_out is active-high, resting at 0.
//
// Parameters:
//   WIDTH  - width of period, high_len and the internal phase counter
//   CNT_W  - width of n_pulses and pulse_idx
//
// Ports:
//   clk        in   system clock, rising edge
//   reset      in   asynchronous active-low reset (0 = reset, 1 = run)
//   tick       in   one-cycle strobe, advances the phase by one
//   start      in   one-cycle request to begin a train (accepted in IDLE only)
//   stop       in   abort request (wins over start)
//   period     in   ticks per output period, latched on accepted start
//   high_len   in   ticks pulse_out is active per period, latched on start
//   n_pulses   in   periods to emit, 0 = continuous, latched on start
//   polarity   in   (optional) output polarity, latched on start
//   pulse_out  out  registered pulse train
//   busy       out  high in RUN and DONE
//   done       out  one-cycle strobe when a finite train completes
//   pulse_idx  out  0-based index of the current period
// -----------------------------------------------------------------------------
module regular_pulse_gen #(
    parameter int WIDTH = 16,
    parameter int CNT_W = 16
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             tick,
    input  logic             start,
    input  logic             stop,
    input  logic [WIDTH-1:0] period,
    input  logic [WIDTH-1:0] high_len,
    input  logic [CNT_W-1:0] n_pulses,
`ifdef REGULAR_PULSE_POLARITY_EN
    input  logic             polarity,
`endif
    output logic             pulse_out,
    output logic             busy,
    output logic             done,
    output logic [CNT_W-1:0] pulse_idx
);

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_RUN  = 2'd1,
        ST_DONE = 2'd2
    } state_t;

    // -------------------------------------------------------------------------
    // State registers
    // -------------------------------------------------------------------------
    state_t           state_q,      state_d;
    logic [WIDTH-1:0] phase_q,      phase_d;
    logic [CNT_W-1:0] pulse_idx_q,  pulse_idx_d;
    logic [WIDTH-1:0] period_q,     period_d;
    logic [WIDTH-1:0] high_len_q,   high_len_d;
    logic [CNT_W-1:0] n_pulses_q,   n_pulses_d;
    logic             pulse_out_q,  pulse_out_d;
    logic             busy_q,       busy_d;
    logic             done_q,       done_d;

    // Latched polarity and the polarity that a start accepted this cycle
    // would latch. In the default build both are tied low, so every XOR with
    // them below collapses to the plain active-high behaviour.
    logic             pol_q;
    logic             pol_new;
`ifdef REGULAR_PULSE_POLARITY_EN
    logic             pol_d;
    assign pol_new = polarity;
`else
    assign pol_q   = 1'b0;
    assign pol_new = 1'b0;
`endif

    // -------------------------------------------------------------------------
    // Helper terms for the RUN state
    // -------------------------------------------------------------------------
    logic [WIDTH-1:0] phase_inc;
    logic             at_period_end;
    logic             last_period;
    logic             start_ok;

    assign phase_inc     = phase_q + WIDTH'(1);
    // period_q is never 0 while running (start with period 0 is refused),
    // so period_q-1 is always a valid last phase.
    assign at_period_end = (phase_q == (period_q - WIDTH'(1)));
    assign last_period   = (n_pulses_q != '0) &&
                           (pulse_idx_q == (n_pulses_q - CNT_W'(1)));
    assign start_ok      = start && !stop && (period != '0);

    // -------------------------------------------------------------------------
    // Next-state and registered-output logic
    // -------------------------------------------------------------------------
    always_comb begin
        state_d     = state_q;
        phase_d     = phase_q;
        pulse_idx_d = pulse_idx_q;
        period_d    = period_q;
        high_len_d  = high_len_q;
        n_pulses_d  = n_pulses_q;
        pulse_out_d = pulse_out_q;
        busy_d      = busy_q;
        done_d      = 1'b0;
`ifdef REGULAR_PULSE_POLARITY_EN
        pol_d       = pol_q;
`endif

        unique case (state_q)
            ST_IDLE: begin
                busy_d      = 1'b0;
                pulse_out_d = pol_q;
                if (start_ok) begin
                    period_d    = period;
                    high_len_d  = high_len;
                    n_pulses_d  = n_pulses;
`ifdef REGULAR_PULSE_POLARITY_EN
                    pol_d       = polarity;
`endif
                    phase_d     = '0;
                    pulse_idx_d = '0;
                    state_d     = ST_RUN;
                    busy_d      = 1'b1;
                    // Phase 0 is active whenever the high width is non-zero,
                    // so the first pulse appears without waiting for a tick.
                    pulse_out_d = (high_len != '0) ^ pol_new;
                end
            end

            ST_RUN: begin
                if (stop) begin
                    // Abort: no done strobe, pulse_idx keeps its last value.
                    state_d     = ST_IDLE;
                    busy_d      = 1'b0;
                    pulse_out_d = pol_q;
                end else if (tick) begin
                    if (at_period_end) begin
                        if (last_period) begin
                            state_d     = ST_DONE;
                            done_d      = 1'b1;
                            pulse_out_d = pol_q;
                        end else begin
                            // pulse_idx wraps naturally at 2^CNT_W.
                            phase_d     = '0;
                            pulse_idx_d = pulse_idx_q + CNT_W'(1);
                            pulse_out_d = (high_len_q != '0) ^ pol_q;
                        end
                    end else begin
                        phase_d     = phase_inc;
                        // high_len >= period keeps this true all train long;
                        // high_len == 0 keeps it false.
                        pulse_out_d = (phase_inc < high_len_q) ^ pol_q;
                    end
                end
            end

            ST_DONE: begin
                // One-cycle state; stop or not, the next edge lands in IDLE.
                state_d     = ST_IDLE;
                busy_d      = 1'b0;
                pulse_out_d = pol_q;
            end

            default: begin
                state_d     = ST_IDLE;
                busy_d      = 1'b0;
                pulse_out_d = 1'b0;
            end
        endcase
    end

    // -------------------------------------------------------------------------
    // Register bank
    // -------------------------------------------------------------------------
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q     <= ST_IDLE;
            phase_q     <= '0;
            pulse_idx_q <= '0;
            period_q    <= '0;
            high_len_q  <= '0;
            n_pulses_q  <= '0;
            pulse_out_q <= 1'b0;
            busy_q      <= 1'b0;
            done_q      <= 1'b0;
        end else begin
            state_q     <= state_d;
            phase_q     <= phase_d;
            pulse_idx_q <= pulse_idx_d;
            period_q    <= period_d;
            high_len_q  <= high_len_d;
            n_pulses_q  <= n_pulses_d;
            pulse_out_q <= pulse_out_d;
            busy_q      <= busy_d;
            done_q      <= done_d;
        end
    end

`ifdef REGULAR_PULSE_POLARITY_EN
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            pol_q <= 1'b0;
        end else begin
            pol_q <= pol_d;
        end
    end
`endif

    // -------------------------------------------------------------------------
    // Outputs
    // -------------------------------------------------------------------------
    assign pulse_out = pulse_out_q;
    assign busy      = busy_q;
    assign done      = done_q;
    assign pulse_idx = pulse_idx_q;

endmodule

// File: tb/tb_regular_pulse_gen.sv
// -----------------------------------------------------------------------------
// Testbench for regular_pulse_gen.
// A driver applies one input vector per cycle at the falling edge and pushes
// the expected post-edge outputs into a queue; a monitor pops one entry after
// each rising edge and compares it against the DUT outputs.
// -----------------------------------------------------------------------------
module tb_regular_pulse_gen;

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic        tick = 1'b0;
    logic        start = 1'b0;
    logic        stop = 1'b0;
    logic [15:0] period = '0;
    logic [15:0] high_len = '0;
    logic [15:0] n_pulses = '0;
`ifdef REGULAR_PULSE_POLARITY_EN
    logic        polarity = 1'b0;
`endif
    logic        pulse_out;
    logic        busy;
    logic        done;
    logic [15:0] pulse_idx;

    regular_pulse_gen #(.WIDTH(16), .CNT_W(16)) dut (
        .clk       (clk),
        .reset     (reset),
        .tick      (tick),
        .start     (start),
        .stop      (stop),
        .period    (period),
        .high_len  (high_len),
        .n_pulses  (n_pulses),
`ifdef REGULAR_PULSE_POLARITY_EN
        .polarity  (polarity),
`endif
        .pulse_out (pulse_out),
        .busy      (busy),
        .done      (done),
        .pulse_idx (pulse_idx)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic        po;
        logic        bz;
        logic        dn;
        logic [15:0] idx;
        string       nm;
    } exp_t;

    exp_t exp_q[$];
    int   tests = 0;
    int   fails = 0;

    // Values the driver applies to period/high_len/n_pulses on its next cycle.
    logic [15:0] per_v = '0;
    logic [15:0] hl_v  = '0;
    logic [15:0] n_v   = '0;

    task automatic check(input string nm, input logic [31:0] act, input logic [31:0] expv);
        tests++;
        if (act !== expv) begin
            fails++;
            $display("FAIL %s: got %0h expected %0h", nm, act, expv);
        end
    endtask

    // One stimulus cycle plus its expected outcome after the next rising edge.
    task automatic cyc(input logic t, input logic s, input logic p,
                       input logic po, input logic bz, input logic dn,
                       input int idx, input string nm);
        exp_t e;
        @(negedge clk);
        tick     = t;
        start    = s;
        stop     = p;
        period   = per_v;
        high_len = hl_v;
        n_pulses = n_v;
        e.po  = po;
        e.bz  = bz;
        e.dn  = dn;
        e.idx = 16'(idx);
        e.nm  = nm;
        exp_q.push_back(e);
        $display("[TB] %0t %s: tick=%0b start=%0b stop=%0b per=%0d hl=%0d n=%0d -> exp po=%0b busy=%0b done=%0b idx=%0d",
                 $time, nm, t, s, p, per_v, hl_v, n_v, po, bz, dn, idx);
    endtask

    // Monitor: compares one queued expectation after every rising edge.
    initial begin : monitor
        exp_t e;
        forever begin
            @(posedge clk);
            #1;
            if (exp_q.size() > 0) begin
                e = exp_q.pop_front();
                check({e.nm, ".pulse_out"}, 32'(pulse_out), 32'(e.po));
                check({e.nm, ".busy"},      32'(busy),      32'(e.bz));
                check({e.nm, ".done"},      32'(done),      32'(e.dn));
                check({e.nm, ".pulse_idx"}, 32'(pulse_idx), 32'(e.idx));
            end
        end
    end

    // Finite train with a tick every cycle. After tick k the phase is k%per
    // and the index k/per; the last tick of the last period lands in DONE.
    // At cycle 'poke' a second start with different settings is issued.
    task automatic run_train(input int per, input int hl, input int n, input int poke, input string nm);
        int total;
        total = per * n;
        per_v = 16'(per); hl_v = 16'(hl); n_v = 16'(n);
        cyc(1'b0, 1'b1, 1'b0, (hl != 0), 1'b1, 1'b0, 0, {nm, ".start"});
        for (int k = 1; k <= total; k++) begin
            if (k == poke) begin
                per_v = 16'd2; hl_v = 16'd1; n_v = 16'd1;
            end
            if (k < total)
                cyc(1'b1, (k == poke), 1'b0, ((k % per) < hl), 1'b1, 1'b0, k / per, {nm, ".run"});
            else
                cyc(1'b1, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1, n - 1, {nm, ".done"});
        end
        cyc(1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, n - 1, {nm, ".idle"});
    endtask

    initial begin : driver
        // Reset state
        #1 reset = 1'b0;
        #12;
        check("reset.pulse_out", 32'(pulse_out), 32'd0);
        check("reset.busy",      32'(busy),      32'd0);
        check("reset.done",      32'(done),      32'd0);
        check("reset.pulse_idx", 32'(pulse_idx), 32'd0);
        @(negedge clk);
        reset = 1'b1;
        cyc(1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 0, "idle_tick");

        // Finite train: high after cycles 1,5,9; done 12 cycles after start
        run_train(4, 1, 3, -1, "fin4_1_3");

        // Sparse tick: period 2, high 1, two pulses, tick every 3rd cycle
        per_v = 16'd2; hl_v = 16'd1; n_v = 16'd2;
        cyc(1'b0, 1'b1, 1'b0, 1'b1, 1'b1, 1'b0, 0, "sparse.start");
        for (int j = 1; j <= 12; j++) begin
            if (j < 12)
                cyc((j % 3 == 0), 1'b0, 1'b0, (((j / 3) % 2) == 0), 1'b1, 1'b0, j / 6, "sparse.run");
            else
                cyc(1'b1, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 1, "sparse.done");
        end
        cyc(1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1, "sparse.idle");

        // Continuous mode: 100 ticks of period 5 -> index 20, then stop
        per_v = 16'd5; hl_v = 16'd2; n_v = 16'd0;
        cyc(1'b0, 1'b1, 1'b0, 1'b1, 1'b1, 1'b0, 0, "cont.start");
        for (int k = 1; k <= 100; k++)
            cyc(1'b1, 1'b0, 1'b0, ((k % 5) < 2), 1'b1, 1'b0, k / 5, "cont.run");
        cyc(1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 20, "cont.stop");
        cyc(1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 20, "cont.idle");

        // Clamp cases
        run_train(4, 7, 2, -1, "clamp_hi");
        run_train(4, 0, 2, -1, "clamp_zero");

        // Illegal and simultaneous requests (index 1 left from last train)
        per_v = 16'd0; hl_v = 16'd1; n_v = 16'd1;
        cyc(1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1, "start_per0");
        per_v = 16'd3;
        cyc(1'b0, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 1, "start_stop");
        cyc(1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1, "after_start_stop");
        run_train(4, 2, 2, 1, "restart_in_run");

        // Asynchronous reset mid-train while pulse_out is high
        per_v = 16'd2; hl_v = 16'd1; n_v = 16'd0;
        cyc(1'b0, 1'b1, 1'b0, 1'b1, 1'b1, 1'b0, 0, "arst.start");
        for (int k = 1; k <= 4; k++)
            cyc(1'b1, 1'b0, 1'b0, ((k % 2) < 1), 1'b1, 1'b0, k / 2, "arst.run");
        @(negedge clk);
        tick = 1'b0;
        #2 reset = 1'b0;
        #1;
        $display("[TB] %0t arst: reset dropped between edges", $time);
        check("arst.pulse_out", 32'(pulse_out), 32'd0);
        check("arst.busy",      32'(busy),      32'd0);
        check("arst.pulse_idx", 32'(pulse_idx), 32'd0);
        @(posedge clk);
        @(negedge clk);
        reset = 1'b1;
        run_train(4, 1, 3, -1, "post_reset");

        repeat (2) @(posedge clk);
        #2;
        check("queue_drained", 32'(exp_q.size()), 32'd0);
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
